banco_exhaustivo: RTL and testbench

- Parametrised, clocked exhaustive-test engine for combinational logic under test, with up to N_IMPL alternative implementations driven in parallel.
- Walks every input vector from 0 to 2^N_ENTRADAS-1 and samples all implementation responses after a programmable settle delay.
- Flags every vector on which any response differs from implementation 0, which is the golden channel.
- Reports a saturating mismatch count plus the first failing vector and mask; intended as the synthesizable core of lab benches and on-board self-test.

---
 rtl/banco_pkg.sv | 27 ++
 rtl/banco_exhaustivo_if.sv | 32 +++
 rtl/banco_comparador.sv | 16 +
 rtl/banco_exhaustivo.sv | 114 +++++++++++
 tb/tb_banco_exhaustivo.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/banco_pkg.sv
// Shared definitions for the exhaustive-test benches: FSM state encoding and
// the mismatch-mask helper used by every comparator.
package banco_pkg;

    localparam logic [2:0] ST_REPOSO  = 3'd0;
    localparam logic [2:0] ST_APLICA  = 3'd1;
    localparam logic [2:0] ST_ESPERA  = 3'd2;
    localparam logic [2:0] ST_COMPARA = 3'd3;
    localparam logic [2:0] ST_FIN     = 3'd4;

    typedef enum logic [2:0] {
        REPOSO  = ST_REPOSO,
        APLICA  = ST_APLICA,
        ESPERA  = ST_ESPERA,
        COMPARA = ST_COMPARA,
        FIN     = ST_FIN
    } estado_t;

    // Widest response bus any bench may compare.
    localparam int MAX_IMPL = 16;

    // Bit i is set when implementation i disagrees with the golden bit 0.
    function automatic logic [MAX_IMPL-1:0] calc_mascara(input logic [MAX_IMPL-1:0] r);
        return r ^ {MAX_IMPL{r[0]}};
    endfunction

endpackage

// File: rtl/banco_exhaustivo_if.sv
// Stimulus/response and result bus between the exhaustive-test engine and the
// logic under test plus its controller.
interface banco_exhaustivo_if #(
    parameter int N_ENTRADAS = 4,
    parameter int N_IMPL     = 4,
    parameter int W_ERR      = N_ENTRADAS + 1
);
    logic                  inicio;
    logic                  pausa;
    logic [N_IMPL-1:0]     respuestas;
    logic [N_ENTRADAS-1:0] estimulo;
    logic                  ocupado;
    logic                  fin;
    logic                  hay_error;
    logic [W_ERR-1:0]      cont_errores;
    logic [N_ENTRADAS-1:0] fallo_estimulo;
    logic [N_IMPL-1:0]     fallo_mascara;

    // Controller / device-under-test side.
    modport master (
        output inicio, pausa, respuestas,
        input  estimulo, ocupado, fin, hay_error, cont_errores,
               fallo_estimulo, fallo_mascara
    );

    // Engine side.
    modport slave (
        input  inicio, pausa, respuestas,
        output estimulo, ocupado, fin, hay_error, cont_errores,
               fallo_estimulo, fallo_mascara
    );
endinterface

// File: rtl/banco_comparador.sv
// Combinational golden-channel comparator: reports which implementations
// disagree with implementation 0 and whether any of them does.
module banco_comparador
    import banco_pkg::*;
#(
    parameter int N_IMPL = 4
) (
    input  logic [N_IMPL-1:0] respuestas,
    output logic [N_IMPL-1:0] mascara,
    output logic              discrepancia
);

    assign mascara      = N_IMPL'(calc_mascara(MAX_IMPL'(respuestas)));
    assign discrepancia = |mascara;

endmodule

// File: rtl/banco_exhaustivo.sv
// Exhaustive-test engine: walks every input vector, waits a settle delay,
// compares all implementations to the golden one and records the results.
module banco_exhaustivo
    import banco_pkg::*;
#(
    parameter int N_ENTRADAS = 4,
    parameter int N_IMPL     = 4,
    parameter int LATENCIA   = 0,
    parameter int W_ERR      = N_ENTRADAS + 1
) (
    input logic               clk,
    input logic               rst,
    banco_exhaustivo_if.slave bus
);

    localparam logic [N_ENTRADAS-1:0] EST_MAX = '1;
    localparam logic [3:0] ULTIMA_ESPERA = (LATENCIA == 0) ? 4'd0 : 4'(LATENCIA - 1);

    estado_t               estado_q;
    logic [N_ENTRADAS-1:0] estimulo_q;
    logic [3:0]            espera_q;
    logic [W_ERR-1:0]      cont_q;
    logic [W_ERR-1:0]      cont_d;
    logic                  hay_error_q;
    logic [N_ENTRADAS-1:0] fallo_est_q;
    logic [N_IMPL-1:0]     fallo_masc_q;
    logic                  ocupado_q;
    logic                  fin_q;

    logic [N_IMPL-1:0]     mascara;
    logic                  discrepancia;

    banco_comparador #(.N_IMPL(N_IMPL)) u_comparador (
        .respuestas  (bus.respuestas),
        .mascara     (mascara),
        .discrepancia(discrepancia)
    );

    // NOTE: default assignment first so every path drives cont_d; no latch.
    always_comb begin
        cont_d = cont_q;
        if (discrepancia && (cont_q != '1)) begin
            cont_d = cont_q + 1'b1;
        end
    end

    // NOTE: non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q     <= REPOSO;
            estimulo_q   <= '0;
            espera_q     <= '0;
            cont_q       <= '0;
            hay_error_q  <= 1'b0;
            fallo_est_q  <= '0;
            fallo_masc_q <= '0;
            ocupado_q    <= 1'b0;
            fin_q        <= 1'b0;
        end else if (!bus.pausa) begin
            case (estado_q)
                REPOSO, FIN: begin
                    if (bus.inicio) begin
                        estado_q     <= APLICA;
                        estimulo_q   <= '0;
                        espera_q     <= '0;
                        cont_q       <= '0;
                        hay_error_q  <= 1'b0;
                        fallo_est_q  <= '0;
                        fallo_masc_q <= '0;
                        ocupado_q    <= 1'b1;
                        fin_q        <= 1'b0;
                    end
                end
                APLICA: begin
                    espera_q <= '0;
                    estado_q <= (LATENCIA == 0) ? COMPARA : ESPERA;
                end
                ESPERA: begin
                    espera_q <= espera_q + 1'b1;
                    if (espera_q == ULTIMA_ESPERA) begin
                        estado_q <= COMPARA;
                    end
                end
                COMPARA: begin
                    cont_q <= cont_d;
                    if (discrepancia && !hay_error_q) begin
                        hay_error_q  <= 1'b1;
                        fallo_est_q  <= estimulo_q;
                        fallo_masc_q <= mascara;
                    end
                    // Terminate on all-ones before incrementing, so no wrap.
                    if (estimulo_q == EST_MAX) begin
                        estado_q  <= FIN;
                        ocupado_q <= 1'b0;
                        fin_q     <= 1'b1;
                    end else begin
                        estimulo_q <= estimulo_q + 1'b1;
                        estado_q   <= APLICA;
                    end
                end
                default: estado_q <= REPOSO;
            endcase
        end
    end

    assign bus.estimulo       = estimulo_q;
    assign bus.ocupado        = ocupado_q;
    assign bus.fin            = fin_q;
    assign bus.hay_error      = hay_error_q;
    assign bus.cont_errores   = cont_q;
    assign bus.fallo_estimulo = fallo_est_q;
    assign bus.fallo_mascara  = fallo_masc_q;

endmodule

// File: tb/tb_banco_exhaustivo.sv
// Self-checking bench for banco_exhaustivo: three parameterisations driven
// from a shared clock, table-driven fault patterns and randomized runs.
module tb_banco_exhaustivo;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    banco_exhaustivo_if #(.N_ENTRADAS(4), .N_IMPL(4), .W_ERR(5)) bus0 ();
    banco_exhaustivo_if #(.N_ENTRADAS(4), .N_IMPL(4), .W_ERR(5)) bus1 ();
    banco_exhaustivo_if #(.N_ENTRADAS(2), .N_IMPL(4), .W_ERR(2)) bus2 ();

    banco_exhaustivo #(.N_ENTRADAS(4), .N_IMPL(4), .LATENCIA(0), .W_ERR(5))
        u0 (.clk(clk), .rst(rst), .bus(bus0));
    banco_exhaustivo #(.N_ENTRADAS(4), .N_IMPL(4), .LATENCIA(3), .W_ERR(5))
        u1 (.clk(clk), .rst(rst), .bus(bus1));
    banco_exhaustivo #(.N_ENTRADAS(2), .N_IMPL(4), .LATENCIA(0), .W_ERR(2))
        u2 (.clk(clk), .rst(rst), .bus(bus2));

    // Logic under test: small sum-of-products functions.
    function automatic logic sop4(input logic [3:0] v);
        return (v[0] & v[1]) | (~v[2] & v[3]) | (v[0] & ~v[1] & v[2]);
    endfunction

    function automatic logic sop2(input logic [1:0] v);
        return (v[0] & ~v[1]) | (~v[0] & v[1]);
    endfunction

    // Instance 0: four copies of sop4 with a per-vector fault pattern.
    logic [3:0] err_tab [16];
    assign bus0.respuestas = {4{sop4(bus0.estimulo)}} ^ err_tab[bus0.estimulo];

    // Instance 1: channel 1 is the golden response delayed by two cycles.
    logic d1, d2;
    always_ff @(posedge clk) begin
        d1 <= sop4(bus1.estimulo);
        d2 <= d1;
    end
    assign bus1.respuestas = {sop4(bus1.estimulo), sop4(bus1.estimulo), d2, sop4(bus1.estimulo)};

    // Instance 2: channel 3 always inverted.
    assign bus2.respuestas = {~sop2(bus2.estimulo), {3{sop2(bus2.estimulo)}}};

    logic [2:0] fin_v;
    logic [2:0] ocup_v;
    logic [3:0] est_v [3];
    assign fin_v  = {bus2.fin, bus1.fin, bus0.fin};
    assign ocup_v = {bus2.ocupado, bus1.ocupado, bus0.ocupado};
    assign est_v[0] = bus0.estimulo;
    assign est_v[1] = bus1.estimulo;
    assign est_v[2] = {2'b00, bus2.estimulo};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_inicio(input int k, input logic v);
        case (k)
            0: bus0.inicio = v;
            1: bus1.inicio = v;
            default: bus2.inicio = v;
        endcase
    endtask

    // Start instance k and count cycles from the first APLICA until fin.
    task automatic run(input int k, input int period, output int cycles,
                       output bit walk_ok, output logic occ0);
        walk_ok = 1'b1;
        set_inicio(k, 1'b1);
        @(negedge clk);
        set_inicio(k, 1'b0);
        occ0   = ocup_v[k];
        cycles = 0;
        while (!fin_v[k] && cycles < 2000) begin
            if (int'(est_v[k]) != cycles / period) walk_ok = 1'b0;
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic clear_err();
        for (int v = 0; v < 16; v++) err_tab[v] = 4'h0;
    endtask

    typedef struct {
        int         va;
        logic [3:0] ma;
        int         vb;
        logic [3:0] mb;
        int         exp_cnt;
        bit         exp_hay;
        int         exp_fs;
        logic [3:0] exp_fm;
    } vec_t;

    vec_t tabla [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cycles;
        bit         walk_ok;
        logic       occ0;
        logic [3:0] e_fr;
        logic [4:0] c_fr;
        bit         frozen_ok;
        bit         pause_done;

        tabla[0] = '{0,  4'h0, 0,  4'h0, 0, 1'b0, 0,  4'h0};
        tabla[1] = '{5,  4'h4, 9,  4'h4, 2, 1'b1, 5,  4'h4};
        tabla[2] = '{0,  4'h1, 15, 4'hA, 2, 1'b1, 0,  4'hE};
        tabla[3] = '{15, 4'hA, 15, 4'h0, 1, 1'b1, 15, 4'hA};
        tabla[4] = '{3,  4'hF, 12, 4'h3, 1, 1'b1, 12, 4'hC};

        rst = 1'b1;
        bus0.inicio = 1'b0; bus0.pausa = 1'b0;
        bus1.inicio = 1'b0; bus1.pausa = 1'b0;
        bus2.inicio = 1'b0; bus2.pausa = 1'b0;
        clear_err();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("reset estimulo", bus0.estimulo, 0);
        check("reset ocupado", bus0.ocupado, 0);
        check("reset fin", bus0.fin, 0);
        check("reset hay_error", bus0.hay_error, 0);
        check("reset cont", bus0.cont_errores, 0);
        check("reset fallo_est", bus0.fallo_estimulo, 0);
        check("reset fallo_masc", bus0.fallo_mascara, 0);
        check("reset fin u1", bus1.fin, 0);

        // Golden-agreement run with estimulo walk.
        run(0, 2, cycles, walk_ok, occ0);
        check("t1 ocupado after start", occ0, 1);
        check("t1 walk", walk_ok, 1);
        check("t1 cycles", cycles, 32);
        check("t1 ocupado in FIN", bus0.ocupado, 0);
        check("t1 estimulo holds", bus0.estimulo, 15);

        // Table-driven fault patterns.
        for (int t = 0; t < 5; t++) begin
            clear_err();
            err_tab[tabla[t].va] = err_tab[tabla[t].va] ^ tabla[t].ma;
            err_tab[tabla[t].vb] = err_tab[tabla[t].vb] ^ tabla[t].mb;
            run(0, 2, cycles, walk_ok, occ0);
            check($sformatf("tab%0d cycles", t), cycles, 32);
            check($sformatf("tab%0d cont", t), bus0.cont_errores, tabla[t].exp_cnt);
            check($sformatf("tab%0d hay_error", t), bus0.hay_error, tabla[t].exp_hay);
            check($sformatf("tab%0d fallo_est", t), bus0.fallo_estimulo, tabla[t].exp_fs);
            check($sformatf("tab%0d fallo_masc", t), bus0.fallo_mascara, tabla[t].exp_fm);
        end

        // Randomized fault patterns against a per-vector reference model.
        for (int it = 0; it < 6; it++) begin
            int         m_cnt;
            int         m_first;
            logic [3:0] m_mask;
            m_cnt = 0; m_first = -1; m_mask = 4'h0;
            for (int v = 0; v < 16; v++) begin
                err_tab[v] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            end
            for (int v = 0; v < 16; v++) begin
                logic [3:0] r;
                logic [3:0] diff;
                r    = {4{sop4(4'(v))}} ^ err_tab[v];
                diff = 4'h0;
                for (int i = 0; i < 4; i++) if (r[i] != r[0]) diff[i] = 1'b1;
                if (diff != 4'h0) begin
                    m_cnt++;
                    if (m_first < 0) begin
                        m_first = v;
                        m_mask  = diff;
                    end
                end
            end
            if (m_cnt > 31) m_cnt = 31;
            run(0, 2, cycles, walk_ok, occ0);
            check($sformatf("rnd%0d cycles", it), cycles, 32);
            check($sformatf("rnd%0d cont", it), bus0.cont_errores, m_cnt);
            check($sformatf("rnd%0d hay_error", it), bus0.hay_error, (m_first >= 0) ? 1 : 0);
            check($sformatf("rnd%0d fallo_est", it), bus0.fallo_estimulo, (m_first >= 0) ? m_first : 0);
            check($sformatf("rnd%0d fallo_masc", it), bus0.fallo_mascara, m_mask);
        end

        // Reset mid-run at vector 7, after a mismatch was recorded at 5.
        clear_err();
        err_tab[5] = 4'h4;
        err_tab[9] = 4'h4;
        set_inicio(0, 1'b1);
        @(negedge clk);
        set_inicio(0, 1'b0);
        cycles = 0;
        while (bus0.estimulo != 4'd7 && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        check("rst reached vector 7", bus0.estimulo, 7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst estimulo", bus0.estimulo, 0);
        check("rst ocupado", bus0.ocupado, 0);
        check("rst fin", bus0.fin, 0);
        check("rst hay_error", bus0.hay_error, 0);
        check("rst cont", bus0.cont_errores, 0);
        check("rst fallo_est", bus0.fallo_estimulo, 0);
        check("rst fallo_masc", bus0.fallo_mascara, 0);
        clear_err();
        run(0, 2, cycles, walk_ok, occ0);
        check("rst rerun walk", walk_ok, 1);
        check("rst rerun cycles", cycles, 32);
        check("rst rerun cont", bus0.cont_errores, 0);
        check("rst rerun hay_error", bus0.hay_error, 0);

        // Pause for 10 cycles starting in COMPARA of a failing vector,
        // plus inicio pulses while busy.
        err_tab[5] = 4'h4;
        err_tab[9] = 4'h4;
        frozen_ok  = 1'b1;
        pause_done = 1'b0;
        set_inicio(0, 1'b1);
        @(negedge clk);
        set_inicio(0, 1'b0);
        cycles = 0;
        while (!bus0.fin && cycles < 2000) begin
            if (!pause_done && bus0.estimulo == 4'd5 && (cycles % 2) == 1) begin
                bus0.pausa = 1'b1;
                e_fr = bus0.estimulo;
                c_fr = bus0.cont_errores;
                for (int i = 0; i < 10; i++) begin
                    bus0.inicio = (i == 4);
                    @(negedge clk);
                    cycles++;
                    if (bus0.estimulo != e_fr || bus0.cont_errores != c_fr || !bus0.ocupado)
                        frozen_ok = 1'b0;
                end
                bus0.inicio = 1'b0;
                bus0.pausa  = 1'b0;
                pause_done  = 1'b1;
            end else begin
                bus0.inicio = (bus0.estimulo == 4'd10);
                @(negedge clk);
                cycles++;
            end
        end
        bus0.inicio = 1'b0;
        check("pause frozen", frozen_ok, 1);
        check("pause applied", pause_done, 1);
        check("pause cycles", cycles, 42);
        check("pause cont", bus0.cont_errores, 2);
        check("pause fallo_est", bus0.fallo_estimulo, 5);
        check("pause fallo_masc", bus0.fallo_mascara, 4'h4);

        // pausa in FIN blocks inicio; results stay readable.
        bus0.pausa  = 1'b1;
        bus0.inicio = 1'b1;
        repeat (2) @(negedge clk);
        bus0.inicio = 1'b0;
        bus0.pausa  = 1'b0;
        @(negedge clk);
        check("fin pausa blocks inicio", bus0.fin, 1);
        check("fin pausa ocupado", bus0.ocupado, 0);
        check("fin results held", bus0.cont_errores, 2);

        // Settle latency 3 with a two-cycle-delayed channel.
        run(1, 5, cycles, walk_ok, occ0);
        check("lat3 walk", walk_ok, 1);
        check("lat3 cycles", cycles, 80);
        check("lat3 cont", bus1.cont_errores, 0);
        check("lat3 hay_error", bus1.hay_error, 0);

        // Two inputs, 2-bit counter saturating at 3 with 4 mismatches.
        run(2, 2, cycles, walk_ok, occ0);
        check("sat cycles", cycles, 8);
        check("sat cont", bus2.cont_errores, 3);
        check("sat hay_error", bus2.hay_error, 1);
        check("sat fallo_est", bus2.fallo_estimulo, 0);
        check("sat fallo_masc", bus2.fallo_mascara, 4'h8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
